// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// No ports; imported (or scope-referenced) by _muldiv_addsub and _muldiv_unit.
package muldiv_pkg;

  localparam int XLEN   = 32;
  localparam int ITERS  = 32;
  localparam int REG_AW = 3;
  localparam int CNT_W  = 6;

  typedef enum logic [1:0] {
    MUL   = 2'b00,
    MULHU = 2'b01,
    DIVU  = 2'b10,
    REMU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } muldiv_state_t;

endpackage

// File: rtl/_muldiv_addsub.sv
// Combinational (XLEN+1)-bit adder/subtractor shared by the multiply
// accumulate and the divide trial subtract.
// Ports:
//   x, y  in  W   operands
//   sub   in  1   0: x + y, 1: x - y
//   res   out W   sum / difference
//   cout  out 1   carry out (add) or borrow (sub, 1 means x < y)
module _muldiv_addsub
  import muldiv_pkg::*;
#(
  parameter int W = XLEN + 1
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         sub,
  output logic [W-1:0] res,
  output logic         cout
);

  always_comb begin
    if (sub) begin
      {cout, res} = {1'b0, x} - {1'b0, y};
    end else begin
      {cout, res} = {1'b0, x} + {1'b0, y};
    end
  end

endmodule

// File: rtl/_muldiv_unit.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU unit with a one-cycle register-file
// write-back strobe. Fixed 34-cycle latency from accept to register-file write.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start, op, a, b,rd request, opcode, operands, destination (sampled in IDLE)
//   busy               high in RUN and DONE
//   done, we3          one-cycle completion / write strobe
//   a3, wd3            latched destination, result (wd3 zero outside done)
module _muldiv_unit #(
  parameter int XLEN  = muldiv_pkg::XLEN,
  parameter int ITERS = muldiv_pkg::ITERS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [1:0]                    op,
  input  logic [XLEN-1:0]               a,
  input  logic [XLEN-1:0]               b,
  input  logic [muldiv_pkg::REG_AW-1:0] rd,
  output logic                          busy,
  output logic                          done,
  output logic                          we3,
  output logic [muldiv_pkg::REG_AW-1:0] a3,
  output logic [XLEN-1:0]               wd3
);

  localparam int CNT_W  = muldiv_pkg::CNT_W;
  localparam int REG_AW = muldiv_pkg::REG_AW;

  typedef muldiv_pkg::muldiv_state_t state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          op_q, op_d;
  logic [REG_AW-1:0]   rd_q, rd_d;
  // hi: multiply high word / divide remainder
  // lo: multiply low word  / divide quotient
  // opnd: multiplicand a   / divisor b
  logic [XLEN-1:0]     hi_q, hi_d;
  logic [XLEN-1:0]     lo_q, lo_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic [XLEN-1:0]     wd3_q, wd3_d;

  logic                is_div;
  logic                iter_last;
  logic [XLEN:0]       as_x, as_y, as_res;
  logic                as_cout;

  assign is_div    = op_q[1];
  // cnt_q counts completed iterations; the extra RUN cycle after the last
  // iteration registers the selected result into wd3.
  assign iter_last = (cnt_q == CNT_W'(ITERS));

  always_comb begin
    if (is_div) begin
      as_x = {hi_q, lo_q[XLEN-1]};
      as_y = {1'b0, opnd_q};
    end else begin
      as_x = {1'b0, hi_q};
      as_y = lo_q[0] ? {1'b0, opnd_q} : '0;
    end
  end

  _muldiv_addsub #(.W(XLEN + 1)) u_addsub (
    .x    (as_x),
    .y    (as_y),
    .sub  (is_div),
    .res  (as_res),
    .cout (as_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= muldiv_pkg::IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      wd3_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      wd3_q   <= wd3_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      muldiv_pkg::IDLE: if (start) state_d = muldiv_pkg::RUN;
      muldiv_pkg::RUN:  if (iter_last) state_d = muldiv_pkg::DONE;
      muldiv_pkg::DONE: state_d = muldiv_pkg::IDLE;
      default:          state_d = muldiv_pkg::IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != muldiv_pkg::IDLE);
    done = (state_q == muldiv_pkg::DONE);
    we3  = done;
    a3   = rd_q;
    wd3  = wd3_q;
  end

  always_comb begin
    cnt_d  = cnt_q;
    op_d   = op_q;
    rd_d   = rd_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
    wd3_d  = '0;
    case (state_q)
      muldiv_pkg::IDLE: begin
        if (start) begin
          op_d  = op;
          rd_d  = rd;
          cnt_d = '0;
          hi_d  = '0;
          if (op[1]) begin
            lo_d   = a;
            opnd_d = b;
          end else begin
            lo_d   = b;
            opnd_d = a;
          end
        end
      end
      muldiv_pkg::RUN: begin
        if (!iter_last) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (is_div) begin
            // Borrow clear means the shifted remainder covers the divisor.
            hi_d = as_cout ? {hi_q[XLEN-2:0], lo_q[XLEN-1]} : as_res[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], ~as_cout};
          end else begin
            // {carry, hi, lo} >> 1, carry being as_res[XLEN]
            hi_d = as_res[XLEN:1];
            lo_d = {as_res[0], lo_q[XLEN-1:1]};
          end
        end else begin
          case (op_q)
            muldiv_pkg::MUL:   wd3_d = lo_q;
            muldiv_pkg::MULHU: wd3_d = hi_q;
            muldiv_pkg::DIVU:  wd3_d = lo_q;
            default:           wd3_d = hi_q;
          endcase
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb__muldiv_unit.sv
module tb__muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [2:0]  rd = '0;
  logic        busy, done, we3;
  logic [2:0]  a3;
  logic [31:0] wd3;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  typedef struct {
    logic [2:0]  rd;
    logic [31:0] data;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  _muldiv_unit #(.XLEN(32), .ITERS(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .rd    (rd),
    .busy  (busy),
    .done  (done),
    .we3   (we3),
    .a3    (a3),
    .wd3   (wd3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst) begin
      check("done_eq_we3", 32'(we3), 32'(done));
      if (we3) begin
        if (sb.size() == 0) begin
          check("unexpected_write", 32'(we3), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("wd3", wd3, mon_e.data);
          check("a3", 32'(a3), 32'(mon_e.rd));
          check("write_latency", 32'(cyc - mon_e.acc), 32'd33);
        end
      end else if (wd3 !== 32'd0) begin
        check("wd3_zero_outside_done", wd3, 32'd0);
      end
    end
  end

  task automatic accept(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [2:0] r, output int k);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; rd = r;
    @(posedge clk);
    #1;
    k = cyc;
    start = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
    // post-accept input changes must not matter
    op = ~o; a = ~x; b = y ^ 32'h5A5A_0F0F; rd = ~r;
  endtask

  task automatic wait_idle(input int k);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 60);
    if (busy) check("busy_timeout", 32'(busy), 32'd0);
    else      check("busy_drop_cycle", 32'(cyc - k), 32'd34);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [2:0] r, input logic [31:0] exp_v);
    int k;
    accept(o, x, y, r, k);
    sb.push_back('{rd: r, data: exp_v, acc: k});
    wait_idle(k);
  endtask

  typedef struct {
    logic [1:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    logic [2:0]  r;
    logic [31:0] e;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int k;
    int n;
    int busy_seen;

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_we3", 32'(we3), 32'd0);
    check("rst_a3", 32'(a3), 32'd0);
    check("rst_wd3", wd3, 32'd0);
    rst = 1'b0;

    vecs.push_back('{2'b00, 32'd7,         32'd6,         3'd3, 32'h0000_002A});
    vecs.push_back('{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd1, 32'h0000_0001});
    vecs.push_back('{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd2, 32'hFFFF_FFFE});
    vecs.push_back('{2'b10, 32'd100,       32'd7,         3'd4, 32'h0000_000E});
    vecs.push_back('{2'b11, 32'd100,       32'd7,         3'd5, 32'h0000_0002});
    vecs.push_back('{2'b10, 32'h0000_1234, 32'd0,         3'd6, 32'hFFFF_FFFF});
    vecs.push_back('{2'b11, 32'h0000_1234, 32'd0,         3'd7, 32'h0000_1234});
    vecs.push_back('{2'b01, 32'h8000_0000, 32'd4,         3'd0, 32'h0000_0002});
    vecs.push_back('{2'b00, 32'h0001_0000, 32'h0001_0000, 3'd3, 32'h0000_0000});
    vecs.push_back('{2'b10, 32'hFFFF_FFFF, 32'd1,         3'd2, 32'hFFFF_FFFF});
    vecs.push_back('{2'b11, 32'd5,         32'd9,         3'd1, 32'h0000_0005});
    vecs.push_back('{2'b10, 32'hFFFF_FFFF, 32'h8000_0000, 3'd6, 32'h0000_0001});

    foreach (vecs[i]) run_op(vecs[i].o, vecs[i].x, vecs[i].y, vecs[i].r, vecs[i].e);

    // start while busy (RUN cycle 5 and the DONE cycle) is ignored
    accept(2'b00, 32'd3, 32'd5, 3'd2, k);
    sb.push_back('{rd: 3'd2, data: 32'h0000_000F, acc: k});
    repeat (5) @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'd99; b = 32'd3; rd = 3'd6;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", 32'(done), 32'd1);
    start = 1'b1; op = 2'b01; a = 32'd11; b = 32'd13; rd = 3'd7;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_done_start", 32'(busy), 32'd0);
    busy_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    check("no_second_op", 32'(busy_seen), 32'd0);

    // reset at RUN cycle 10 aborts
    accept(2'b00, 32'd3, 32'd5, 3'd4, k);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_run_busy", 32'(busy), 32'd0);
    check("abort_run_we3", 32'(we3), 32'd0);
    check("abort_run_wd3", wd3, 32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    // reset sampled on the edge that would enter DONE: no write-back
    accept(2'b10, 32'd100, 32'd7, 3'd5, k);
    while (cyc < k + 32) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_done_busy", 32'(busy), 32'd0);
    check("abort_done_we3", 32'(we3), 32'd0);
    check("abort_done_wd3", wd3, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    run_op(2'b10, 32'd100, 32'd7, 3'd5, 32'h0000_000E);
    run_op(2'b00, 32'd7, 32'd6, 3'd3, 32'h0000_002A);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
